// File: rtl/pixel_fifo_gen.sv
// pixel_fifo_gen: multi-lane pixel FIFO with selectable registered or show-ahead read
module pixel_fifo_gen #(
  parameter int PIX_WIDTH  = 16,
  parameter int LANES      = 1,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 1,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             load,
  input  logic [LANES*PIX_WIDTH-1:0]       pix_in,
  input  logic                             req_out,
  output logic [LANES*PIX_WIDTH-1:0]       pix_out,
  output logic                             ack_out,
  output logic [$clog2(DEPTH+1)-1:0]       fill,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic                             overflow,
  output logic                             underflow
);
  localparam int W  = LANES * PIX_WIDTH;
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  pix_q;
  logic          ack_q, pop_acc, push_acc;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full         = fill == FW'(DEPTH);
  assign empty        = fill == '0;
  assign almost_full  = fill >= FW'(AFULL_TH);
  assign almost_empty = fill <= FW'(AEMPTY_TH);
  assign pop_acc      = req_out & ~empty;
  assign push_acc     = load & (~full | pop_acc);
  // Show-ahead masks the unreset storage so pix_out reads 0 while empty.
  assign pix_out = SHOW_AHEAD != 0 ? (empty ? '0 : mem[rd_ptr]) : pix_q;
  assign ack_out = SHOW_AHEAD != 0 ? ~empty : ack_q;
  always_ff @(posedge clk)
    if (push_acc && !flush) mem[wr_ptr] <= pix_in;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ack_q     <= 1'b0;
      pix_q     <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= nxt(wr_ptr);
      if (pop_acc) rd_ptr <= nxt(rd_ptr);
      if (pop_acc) pix_q <= mem[rd_ptr];
      fill      <= fill + FW'(push_acc) - FW'(pop_acc);
      overflow  <= overflow | (load & ~push_acc);
      underflow <= underflow | (req_out & empty);
      ack_q     <= pop_acc;
    end
  end
endmodule
